// File: rtl/leaf_router_rr_if.sv
// leaf_router_rr_if
//   Bundles the valid/ready channels of leaf_router_rr: one GPU ingress and
//   egress channel plus NUM_SPINES spine ingress/egress channels, each spine
//   lane i occupying slice [i*WIDTH +: WIDTH] of the packed buses.
//   master : traffic side (drives ingress flits and egress readies)
//   slave  : router side  (drives ingress readies and egress flits)
interface leaf_router_rr_if #(
  parameter int DWIDTH     = 16,
  parameter int ADDR_W     = 6,
  parameter int NUM_SPINES = 4
);
  logic [DWIDTH-1:0]            gpu_in_data;
  logic [ADDR_W-1:0]            gpu_in_dest;
  logic                         gpu_in_valid;
  logic                         gpu_in_ready;
  logic [DWIDTH-1:0]            gpu_out_data;
  logic                         gpu_out_valid;
  logic                         gpu_out_ready;
  logic [NUM_SPINES*DWIDTH-1:0] spine_in_data;
  logic [NUM_SPINES*ADDR_W-1:0] spine_in_dest;
  logic [NUM_SPINES-1:0]        spine_in_valid;
  logic [NUM_SPINES-1:0]        spine_in_ready;
  logic [NUM_SPINES*DWIDTH-1:0] spine_out_data;
  logic [NUM_SPINES*ADDR_W-1:0] spine_out_dest;
  logic [NUM_SPINES-1:0]        spine_out_valid;
  logic [NUM_SPINES-1:0]        spine_out_ready;

  modport master (
    output gpu_in_data, gpu_in_dest, gpu_in_valid, gpu_out_ready,
    output spine_in_data, spine_in_dest, spine_in_valid, spine_out_ready,
    input  gpu_in_ready, gpu_out_data, gpu_out_valid,
    input  spine_in_ready, spine_out_data, spine_out_dest, spine_out_valid
  );

  modport slave (
    input  gpu_in_data, gpu_in_dest, gpu_in_valid, gpu_out_ready,
    input  spine_in_data, spine_in_dest, spine_in_valid, spine_out_ready,
    output gpu_in_ready, gpu_out_data, gpu_out_valid,
    output spine_in_ready, spine_out_data, spine_out_dest, spine_out_valid
  );
endinterface

// File: rtl/leaf_router_rr.sv
// leaf_router_rr
//   Leaf router between one GPU endpoint and NUM_SPINES spine ports.
//   Every input has a FIFO of {dest, data}. FIFO heads are routed by group:
//     GPU head, local group     -> GPU output (loopback, arbitrated)
//     GPU head, remote group    -> spine dest[clog2(NUM_SPINES)-1:0]
//     spine head, local group   -> GPU output (arbitrated)
//     spine head, remote group  -> discarded, counted in drop_count
//   The GPU output is shared round-robin (search from current_grant+1).
//   Every output port has one register stage that reloads when empty or
//   when its flit is taken in the same cycle.
// Ports
//   clk           clock
//   reset         asynchronous active-low reset
//   bus           leaf_router_rr_if.slave: GPU and spine valid/ready channels
//   fifo_full     input FIFO full flags  (bit 0 = GPU, bit i+1 = spine i)
//   fifo_empty    input FIFO empty flags (same order)
//   current_grant last source granted onto the GPU output (0 = GPU)
//   drop_count    saturating count of discarded misrouted spine flits
module leaf_router_rr #(
  parameter int                 DWIDTH     = 16,
  parameter int                 ADDR_W     = 6,
  parameter int                 GROUP_W    = 4,
  parameter logic [GROUP_W-1:0] GROUP_ID   = 4'b0011,
  parameter int                 NUM_SPINES = 4,
  parameter int                 FIFO_DEPTH = 8
) (
  input  logic                                clk,
  input  logic                                reset,
  leaf_router_rr_if.slave                     bus,
  output logic [NUM_SPINES:0]                 fifo_full,
  output logic [NUM_SPINES:0]                 fifo_empty,
  output logic [$clog2(NUM_SPINES+1)-1:0]     current_grant,
  output logic [15:0]                         drop_count
);
  localparam int NP = NUM_SPINES + 1;
  localparam int GW = $clog2(NP);
  localparam int SW = $clog2(NUM_SPINES);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int EW = ADDR_W + DWIDTH;
  localparam logic [AW:0] PTR_FULL = (AW+1)'(FIFO_DEPTH);

  logic [EW-1:0]                r_mem [NP][FIFO_DEPTH];
  logic [AW:0]                  r_wptr [NP];
  logic [AW:0]                  r_rptr [NP];
  logic                         r_live;
  logic                         r_gpu_valid;
  logic [DWIDTH-1:0]            r_gpu_data;
  logic [GW-1:0]                r_grant;
  logic [NUM_SPINES-1:0]        r_sp_valid;
  logic [NUM_SPINES*DWIDTH-1:0] r_sp_data;
  logic [NUM_SPINES*ADDR_W-1:0] r_sp_dest;
  logic [15:0]                  r_drop;

  logic [NP-1:0]         w_in_valid, w_push, w_pop, w_full, w_empty, w_ready, w_local;
  logic [EW-1:0]         w_in_entry [NP];
  logic [EW-1:0]         w_head [NP];
  logic [SW-1:0]         w_gpu_tgt;
  logic [NUM_SPINES-1:0] w_sp_load, w_drop;
  logic                  w_gnt;
  logic [GW-1:0]         w_win;
  logic [GW:0]           w_sum;
  logic [16:0]           w_drop_sum;
  logic [15:0]           w_drop_nxt;

  // Per-FIFO view of the ingress channels (index 0 = GPU, i+1 = spine i).
  always_comb begin
    w_in_valid    = '0;
    w_in_valid[0] = bus.gpu_in_valid;
    w_in_entry[0] = {bus.gpu_in_dest, bus.gpu_in_data};
    for (int i = 0; i < NUM_SPINES; i++) begin
      w_in_valid[i+1] = bus.spine_in_valid[i];
      w_in_entry[i+1] = {bus.spine_in_dest[i*ADDR_W +: ADDR_W],
                         bus.spine_in_data[i*DWIDTH +: DWIDTH]};
    end
  end

  // FIFO status, heads and locality; ready depends only on fullness.
  always_comb begin
    for (int p = 0; p < NP; p++) begin
      w_empty[p] = (r_wptr[p] == r_rptr[p]);
      w_full[p]  = ((r_wptr[p] - r_rptr[p]) == PTR_FULL);
      w_head[p]  = r_mem[p][r_rptr[p][AW-1:0]];
      w_local[p] = !w_empty[p] && (w_head[p][EW-1 -: GROUP_W] == GROUP_ID);
    end
    w_ready = {NP{r_live}} & ~w_full;
    w_push  = w_in_valid & w_ready;
  end

  // Routing, drops, round-robin GPU arbitration, pops and drop accounting.
  always_comb begin
    w_gpu_tgt = w_head[0][DWIDTH +: SW];
    w_sp_load = '0;
    if (!w_empty[0] && !w_local[0] &&
        (!r_sp_valid[w_gpu_tgt] || bus.spine_out_ready[w_gpu_tgt])) begin
      w_sp_load[w_gpu_tgt] = 1'b1;
    end else begin
      w_sp_load = '0;
    end
    for (int i = 0; i < NUM_SPINES; i++) begin
      w_drop[i] = !w_empty[i+1] && !w_local[i+1];
    end
    // Locality flags double as GPU-output requests: a local GPU head is loopback.
    w_gnt = 1'b0;
    w_win = r_grant;
    w_sum = '0;
    if (!r_gpu_valid || bus.gpu_out_ready) begin
      for (int k = 1; k <= NP; k++) begin
        w_sum = {1'b0, r_grant} + (GW+1)'(k);
        w_sum = (w_sum >= (GW+1)'(NP)) ? (w_sum - (GW+1)'(NP)) : w_sum;
        if (!w_gnt && w_local[w_sum[GW-1:0]]) begin
          w_gnt = 1'b1;
          w_win = w_sum[GW-1:0];
        end else begin
          w_gnt = w_gnt;
        end
      end
    end else begin
      w_gnt = 1'b0;
    end
    w_pop         = '0;
    w_pop[0]      = |w_sp_load;
    w_pop[NP-1:1] = w_drop;
    if (w_gnt) begin
      w_pop[w_win] = 1'b1;
    end else begin
      w_pop = w_pop;
    end
    // Several spines may drop in one cycle; add them all, then saturate.
    w_drop_sum = {1'b0, r_drop};
    for (int i = 0; i < NUM_SPINES; i++) begin
      w_drop_sum = w_drop_sum + 17'(w_drop[i]);
    end
    w_drop_nxt = w_drop_sum[16] ? 16'hFFFF : w_drop_sum[15:0];
  end

  // Ingress readies stay low until the first edge after reset release.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_live <= 1'b0;
    else        r_live <= 1'b1;
  end

  // FIFO read/write pointers (one extra bit distinguishes full from empty).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int p = 0; p < NP; p++) begin
        r_wptr[p] <= '0;
        r_rptr[p] <= '0;
      end
    end else begin
      for (int p = 0; p < NP; p++) begin
        if (w_push[p]) r_wptr[p] <= r_wptr[p] + {{AW{1'b0}}, 1'b1};
        if (w_pop[p])  r_rptr[p] <= r_rptr[p] + {{AW{1'b0}}, 1'b1};
      end
    end
  end

  // FIFO storage; contents are only read while non-empty, so no reset.
  always_ff @(posedge clk) begin
    for (int p = 0; p < NP; p++) begin
      if (w_push[p]) r_mem[p][r_wptr[p][AW-1:0]] <= w_in_entry[p];
    end
  end

  // GPU output register and grant pointer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_gpu_valid <= 1'b0;
      r_gpu_data  <= '0;
      r_grant     <= '0;
    end else if (w_gnt) begin
      r_gpu_valid <= 1'b1;
      r_gpu_data  <= w_head[w_win][DWIDTH-1:0];
      r_grant     <= w_win;
    end else if (bus.gpu_out_ready) begin
      r_gpu_valid <= 1'b0;
    end
  end

  // Spine output registers, fed only from the GPU FIFO.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sp_valid <= '0;
      r_sp_data  <= '0;
      r_sp_dest  <= '0;
    end else begin
      for (int i = 0; i < NUM_SPINES; i++) begin
        if (w_sp_load[i]) begin
          r_sp_valid[i]                  <= 1'b1;
          r_sp_data[i*DWIDTH +: DWIDTH]  <= w_head[0][DWIDTH-1:0];
          r_sp_dest[i*ADDR_W +: ADDR_W]  <= w_head[0][EW-1 -: ADDR_W];
        end else if (bus.spine_out_ready[i]) begin
          r_sp_valid[i] <= 1'b0;
        end
      end
    end
  end

  // Saturating drop counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_drop <= '0;
    else        r_drop <= w_drop_nxt;
  end

  assign bus.gpu_in_ready    = w_ready[0];
  assign bus.spine_in_ready  = w_ready[NP-1:1];
  assign bus.gpu_out_valid   = r_gpu_valid;
  assign bus.gpu_out_data    = r_gpu_data;
  assign bus.spine_out_valid = r_sp_valid;
  assign bus.spine_out_data  = r_sp_data;
  assign bus.spine_out_dest  = r_sp_dest;
  assign fifo_full           = w_full;
  assign fifo_empty          = w_empty;
  assign current_grant       = r_grant;
  assign drop_count          = r_drop;
endmodule

// File: tb/tb_leaf_router_rr.sv
// tb_leaf_router_rr
//   Self-checking bench for leaf_router_rr: directed scenarios with cycle-exact
//   expectations plus a randomized phase checked by a transaction scoreboard
//   (per-source ordering, loss/duplication, drop accounting).
module tb_leaf_router_rr;
  localparam int DW  = 16;
  localparam int AWD = 6;
  localparam int NS  = 4;
  localparam int NP  = NS + 1;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [NS:0] fifo_full, fifo_empty;
  logic [2:0]  current_grant;
  logic [15:0] drop_count;

  leaf_router_rr_if #(.DWIDTH(DW), .ADDR_W(AWD), .NUM_SPINES(NS)) bus ();

  leaf_router_rr #(
    .DWIDTH(DW), .ADDR_W(AWD), .GROUP_W(4), .GROUP_ID(4'b0011),
    .NUM_SPINES(NS), .FIFO_DEPTH(8)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus),
    .fifo_full(fifo_full), .fifo_empty(fifo_empty),
    .current_grant(current_grant), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          exp_drop = 0;
  logic [19:0] exp_gpu_q[$];  // {source, data} awaiting the GPU output
  logic [31:0] exp_sp_q[$];   // {port, dest, data} awaiting a spine output
  logic [15:0] rx_log[$];     // flits seen on the GPU output, in order

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic is_local(input logic [AWD-1:0] d);
    return d[AWD-1 -: 4] == 4'b0011;
  endfunction

  function automatic logic [AWD-1:0] rand_dest(input int pct_local);
    logic [3:0] g;
    g = ($urandom_range(0, 99) < pct_local) ? 4'b0011 : 4'($urandom);
    return {g, 2'($urandom)};
  endfunction

  task automatic gpu_rx(input logic [15:0] d);
    int idx;
    int pend;
    idx  = -1;
    pend = 0;
    for (int j = 0; j < exp_gpu_q.size(); j++) begin
      if (exp_gpu_q[j][19:16] == d[15:12]) begin
        pend++;
        if (idx < 0) idx = j;
      end
    end
    check("gpu_pending", 32'(pend > 0), 32'd1);
    if (idx >= 0) begin
      check("gpu_data", {16'd0, d}, {16'd0, exp_gpu_q[idx][15:0]});
      exp_gpu_q.delete(idx);
    end
    rx_log.push_back(d);
  endtask

  task automatic spine_rx(input int port, input logic [AWD-1:0] dst, input logic [15:0] d);
    int idx;
    idx = -1;
    for (int j = 0; j < exp_sp_q.size(); j++) begin
      if (idx < 0 && exp_sp_q[j][23:22] == 2'(port)) idx = j;
    end
    check("spine_pending", 32'(idx >= 0), 32'd1);
    if (idx >= 0) begin
      check("spine_flit", {10'd0, dst, d}, {10'd0, exp_sp_q[idx][21:0]});
      exp_sp_q.delete(idx);
    end
  endtask

  // Called at a negedge with inputs already driven: score this cycle's
  // handshakes, then advance to the next negedge.
  task automatic cycle();
    if (bus.gpu_in_valid && bus.gpu_in_ready) begin
      if (is_local(bus.gpu_in_dest)) exp_gpu_q.push_back({4'd0, bus.gpu_in_data});
      else exp_sp_q.push_back({8'd0, bus.gpu_in_dest[1:0], bus.gpu_in_dest, bus.gpu_in_data});
    end
    for (int i = 0; i < NS; i++) begin
      if (bus.spine_in_valid[i] && bus.spine_in_ready[i]) begin
        if (is_local(bus.spine_in_dest[i*AWD +: AWD]))
          exp_gpu_q.push_back({4'(i+1), bus.spine_in_data[i*DW +: DW]});
        else
          exp_drop++;
      end
    end
    if (bus.gpu_out_valid && bus.gpu_out_ready) gpu_rx(bus.gpu_out_data);
    for (int i = 0; i < NS; i++) begin
      if (bus.spine_out_valid[i] && bus.spine_out_ready[i])
        spine_rx(i, bus.spine_out_dest[i*AWD +: AWD], bus.spine_out_data[i*DW +: DW]);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    bus.gpu_in_valid   = 1'b0;
    bus.spine_in_valid = '0;
  endtask

  initial begin
    int sent;
    int n_gpu;
    int n_s3;
    logic [11:0] seq;

    bus.gpu_in_data = '0;  bus.gpu_in_dest = '0;  bus.gpu_in_valid = 1'b0;
    bus.spine_in_data = '0; bus.spine_in_dest = '0; bus.spine_in_valid = '0;
    bus.gpu_out_ready = 1'b0; bus.spine_out_ready = '0;
    seq = 12'd0;

    // Reset state.
    repeat (2) @(negedge clk);
    check("rst_gpu_valid", 32'(bus.gpu_out_valid), 32'd0);
    check("rst_sp_valid", 32'(bus.spine_out_valid), 32'd0);
    check("rst_gpu_data", 32'(bus.gpu_out_data), 32'd0);
    check("rst_sp_data", 32'(bus.spine_out_data), 32'd0);
    check("rst_grant", 32'(current_grant), 32'd0);
    check("rst_drop", 32'(drop_count), 32'd0);
    check("rst_empty", 32'(fifo_empty), 32'h1F);
    check("rst_full", 32'(fifo_full), 32'd0);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("ready_after_rst", 32'({bus.spine_in_ready, bus.gpu_in_ready}), 32'h1F);

    // GPU to remote group 7, spine 1.
    bus.spine_out_ready = 4'hF;
    bus.gpu_out_ready   = 1'b1;
    bus.gpu_in_valid = 1'b1; bus.gpu_in_data = 16'hA5A5; bus.gpu_in_dest = 6'b0111_01;
    cycle();
    idle_inputs();
    cycle();
    check("t2_sp_valid", 32'(bus.spine_out_valid), 32'h2);
    check("t2_sp_data", 32'(bus.spine_out_data[DW +: DW]), 32'hA5A5);
    check("t2_sp_dest", 32'(bus.spine_out_dest[AWD +: AWD]), 32'h1D);
    check("t2_gpu_idle", 32'(bus.gpu_out_valid), 32'd0);
    cycle();

    // All four spines to the local group in one cycle.
    for (int i = 0; i < NS; i++) begin
      bus.spine_in_data[i*DW +: DW] = {4'(i+1), 12'h030};
      bus.spine_in_dest[i*AWD +: AWD] = 6'b0011_00;
    end
    bus.spine_in_valid = 4'hF;
    cycle();
    idle_inputs();
    cycle();
    for (int k = 0; k < NS; k++) begin
      check("t3_valid", 32'(bus.gpu_out_valid), 32'd1);
      check("t3_data", 32'(bus.gpu_out_data), 32'({4'(k+1), 12'h030}));
      check("t3_grant", 32'(current_grant), 32'(k+1));
      cycle();
    end

    // Spine 2 sends to group 5 three times: all dropped.
    bus.spine_in_dest[2*AWD +: AWD] = 6'b0101_00;
    bus.spine_in_valid = 4'b0100;
    for (int k = 0; k < 3; k++) begin
      bus.spine_in_data[2*DW +: DW] = 16'h3E00 + 16'(k);
      check("t4_ready", 32'(bus.spine_in_ready[2]), 32'd1);
      cycle();
    end
    idle_inputs();
    cycle();
    cycle();
    check("t4_drop", 32'(drop_count), 32'd3);
    check("t4_no_out", 32'({bus.spine_out_valid, bus.gpu_out_valid}), 32'd0);

    // Backpressure: spine 0 streams 10 local flits into a stalled GPU output.
    bus.gpu_out_ready = 1'b0;
    rx_log.delete();
    sent = 0;
    bus.spine_in_dest[0 +: AWD] = 6'b0011_00;
    for (int c = 0; c < 14; c++) begin
      logic acc;
      bus.spine_in_valid[0] = (sent < 10);
      bus.spine_in_data[0 +: DW] = 16'h1100 + 16'(sent);
      acc = bus.spine_in_valid[0] && bus.spine_in_ready[0];
      cycle();
      if (acc) sent++;
    end
    check("t5_accepted", 32'(sent), 32'd9);
    check("t5_ready_low", 32'(bus.spine_in_ready[0]), 32'd0);
    check("t5_full", 32'(fifo_full[1]), 32'd1);
    check("t5_hold_valid", 32'(bus.gpu_out_valid), 32'd1);
    check("t5_hold_data", 32'(bus.gpu_out_data), 32'h1100);
    bus.gpu_out_ready = 1'b1;
    for (int c = 0; c < 40 && rx_log.size() < 10; c++) begin
      logic acc;
      bus.spine_in_valid[0] = (sent < 10);
      bus.spine_in_data[0 +: DW] = 16'h1100 + 16'(sent);
      acc = bus.spine_in_valid[0] && bus.spine_in_ready[0];
      cycle();
      if (acc) sent++;
    end
    idle_inputs();
    check("t5_delivered", 32'(rx_log.size()), 32'd10);
    for (int j = 0; j < rx_log.size(); j++) check("t5_order", 32'(rx_log[j]), 32'h1100 + 32'(j));
    cycle();

    // GPU loopback mixed with spine 3 local traffic: grants must alternate.
    bus.gpu_out_ready = 1'b0;
    rx_log.delete();
    bus.gpu_in_dest = 6'b0011_10;
    bus.spine_in_dest[3*AWD +: AWD] = 6'b0011_00;
    for (int k = 0; k < 4; k++) begin
      bus.gpu_in_valid = 1'b1;  bus.gpu_in_data = 16'h0200 + 16'(k);
      bus.spine_in_valid = 4'b1000; bus.spine_in_data[3*DW +: DW] = 16'h4200 + 16'(k);
      cycle();
    end
    idle_inputs();
    bus.gpu_out_ready = 1'b1;
    for (int c = 0; c < 30 && rx_log.size() < 8; c++) cycle();
    check("t6_delivered", 32'(rx_log.size()), 32'd8);
    n_gpu = 0;
    n_s3  = 0;
    for (int j = 0; j < rx_log.size(); j++) begin
      if (rx_log[j][15:12] == 4'd0) n_gpu++;
      if (rx_log[j][15:12] == 4'd4) n_s3++;
      if (j > 0) check("t6_alternate", 32'(rx_log[j][15:12] != rx_log[j-1][15:12]), 32'd1);
    end
    check("t6_gpu_count", 32'(n_gpu), 32'd4);
    check("t6_s3_count", 32'(n_s3), 32'd4);

    // Randomized traffic against the scoreboard.
    for (int c = 0; c < 2000; c++) begin
      bus.gpu_in_valid = 1'($urandom_range(0, 1));
      bus.gpu_in_dest  = rand_dest(40);
      bus.gpu_in_data  = {4'd0, seq};
      for (int i = 0; i < NS; i++) begin
        bus.spine_in_valid[i] = 1'($urandom_range(0, 1));
        bus.spine_in_dest[i*AWD +: AWD] = rand_dest(60);
        bus.spine_in_data[i*DW +: DW] = {4'(i+1), seq};
      end
      bus.gpu_out_ready   = ($urandom_range(0, 9) < 7);
      bus.spine_out_ready = 4'($urandom);
      seq = seq + 12'd1;
      cycle();
    end
    idle_inputs();
    bus.gpu_out_ready   = 1'b1;
    bus.spine_out_ready = 4'hF;
    for (int c = 0; c < 300 && (exp_gpu_q.size() != 0 || exp_sp_q.size() != 0 ||
                                fifo_empty != 5'h1F); c++) cycle();
    check("rand_gpu_left", 32'(exp_gpu_q.size()), 32'd0);
    check("rand_sp_left", 32'(exp_sp_q.size()), 32'd0);
    check("rand_empty", 32'(fifo_empty), 32'h1F);
    check("rand_drop", 32'(drop_count), 32'(exp_drop));

    // Reset in the middle of traffic with outputs valid.
    bus.gpu_out_ready   = 1'b0;
    bus.spine_out_ready = '0;
    for (int k = 0; k < 4; k++) begin
      bus.gpu_in_valid = 1'b1; bus.gpu_in_dest = 6'b0100_10; bus.gpu_in_data = 16'h0700 + 16'(k);
      bus.spine_in_valid = 4'b0010; bus.spine_in_dest[AWD +: AWD] = 6'b0011_01;
      bus.spine_in_data[DW +: DW] = 16'h2700 + 16'(k);
      cycle();
    end
    idle_inputs();
    check("t7_pre_gpu_valid", 32'(bus.gpu_out_valid), 32'd1);
    check("t7_pre_sp_valid", 32'(bus.spine_out_valid), 32'h4);
    #2 reset = 1'b0;
    #1;
    check("t7_gpu_valid", 32'(bus.gpu_out_valid), 32'd0);
    check("t7_sp_valid", 32'(bus.spine_out_valid), 32'd0);
    check("t7_gpu_data", 32'(bus.gpu_out_data), 32'd0);
    exp_gpu_q.delete();
    exp_sp_q.delete();
    rx_log.delete();
    exp_drop = 0;
    @(negedge clk);
    reset = 1'b1;
    check("t7_empty", 32'(fifo_empty), 32'h1F);
    check("t7_full", 32'(fifo_full), 32'd0);
    check("t7_drop", 32'(drop_count), 32'd0);
    check("t7_grant", 32'(current_grant), 32'd0);
    @(posedge clk);
    @(negedge clk);
    check("t7_ready", 32'({bus.spine_in_ready, bus.gpu_in_ready}), 32'h1F);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
